mlp_feature_loader: RTL and testbench

Sequential front end for the combinational bespoke MLP classifiers (6 features × 4 bits in, 2-bit class out). It accepts features one nibble per beat over a valid/ready stream and assembles them into the 24-bit feature vector driven into the classifier's `inp`. It waits a fixed number of settle cycles for the slow printed combinational logic to resolve, captures the class index from `out`, and presents it on a valid/ready result port.

---
 rtl/mlp_loader_pkg.sv | 29 ++
 rtl/mlp_feature_loader.sv | 143 ++++++++++++++
 tb/tb_mlp_feature_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_loader_pkg.sv
// ============================================================================
// Module   : mlp_loader_pkg
// Brief    : Shared state encoding, default sizes and counter width helper
//            for the MLP feature loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mlp_loader_pkg;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2,
      DRAIN  = 2'd3
   } loader_state_e;

   localparam int MLP_N_FEAT = 6;
   localparam int MLP_FEAT_W = 4;
   localparam int MLP_CLS_W  = 2;

   // Bits needed to count 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mlp_feature_loader.sv
// ============================================================================
// Module   : mlp_feature_loader
// Brief    : Streams nibble features into a combinational MLP, waits for the
//            logic to settle, then returns the class on a valid/ready port.
//            Framing checks and DRAIN exist only with MLP_LOADER_FRAME_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mlp_feature_loader
   import mlp_loader_pkg::*;
#(
   parameter int N_FEAT     = MLP_N_FEAT,
   parameter int FEAT_W     = MLP_FEAT_W,
   parameter int CLS_W      = MLP_CLS_W,
   parameter int SETTLE_CYC = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [FEAT_W-1:0]        s_data,
   input  logic                     s_last,
   output logic [N_FEAT*FEAT_W-1:0] feat_vec,
   input  logic [CLS_W-1:0]         cls_in,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [CLS_W-1:0]         m_class,
   output logic                     frame_err
);

   localparam int BEAT_W = cnt_width(N_FEAT);
   localparam int SET_W  = cnt_width(SETTLE_CYC);

   localparam logic [BEAT_W-1:0] c_last_beat   = BEAT_W'(N_FEAT - 1);
   localparam logic [SET_W-1:0]  c_settle_init = SET_W'(SETTLE_CYC - 1);

   localparam logic [1:0] c_st_load   = 2'(LOAD);
   localparam logic [1:0] c_st_settle = 2'(SETTLE);
   localparam logic [1:0] c_st_hold   = 2'(HOLD);
`ifdef MLP_LOADER_FRAME_CHECK_EN
   localparam logic [1:0] c_st_drain  = 2'(DRAIN);
`endif

   logic [1:0]               r_state;
   logic [BEAT_W-1:0]        r_beat_cnt;
   logic [SET_W-1:0]         r_settle_cnt;
   logic [N_FEAT*FEAT_W-1:0] r_feat_vec;
   logic                     r_m_valid;
   logic [CLS_W-1:0]         r_m_class;
   logic                     r_frame_err;
   logic                     w_accept;
   logic                     w_final;

`ifdef MLP_LOADER_FRAME_CHECK_EN
   assign s_ready = (r_state == c_st_load) || (r_state == c_st_drain);
`else
   logic w_unused_s_last;
   assign w_unused_s_last = s_last;
   assign s_ready = (r_state == c_st_load);
`endif

   assign w_accept  = s_valid & s_ready;
   assign w_final   = (r_beat_cnt == c_last_beat);
   assign feat_vec  = r_feat_vec;
   assign m_valid   = r_m_valid;
   assign m_class   = r_m_class;
   assign frame_err = r_frame_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= c_st_load;
         r_beat_cnt   <= '0;
         r_settle_cnt <= '0;
         r_feat_vec   <= '0;
         r_m_valid    <= 1'b0;
         r_m_class    <= '0;
         r_frame_err  <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         case (r_state)
            c_st_load: begin
               if (w_accept) begin
                  for (int k = 0; k < N_FEAT; k++) begin
                     if (r_beat_cnt == BEAT_W'(k))
                        r_feat_vec[k*FEAT_W +: FEAT_W] <= s_data;
                  end
`ifdef MLP_LOADER_FRAME_CHECK_EN
                  // Early last abandons the frame; missing last on the final slot drains to the next last.
                  if (s_last && !w_final) begin
                     r_frame_err <= 1'b1;
                     r_beat_cnt  <= '0;
                  end else if (w_final && !s_last) begin
                     r_frame_err <= 1'b1;
                     r_beat_cnt  <= '0;
                     r_state     <= c_st_drain;
                  end else if (w_final) begin
                     r_beat_cnt   <= '0;
                     r_settle_cnt <= c_settle_init;
                     r_state      <= c_st_settle;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 1'b1;
                  end
`else
                  if (w_final) begin
                     r_beat_cnt   <= '0;
                     r_settle_cnt <= c_settle_init;
                     r_state      <= c_st_settle;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 1'b1;
                  end
`endif
               end
            end
            c_st_settle: begin
               if (r_settle_cnt == '0) begin
                  r_m_class <= cls_in;
                  r_m_valid <= 1'b1;
                  r_state   <= c_st_hold;
               end else begin
                  r_settle_cnt <= r_settle_cnt - 1'b1;
               end
            end
            c_st_hold: begin
               if (m_ready) begin
                  r_m_valid <= 1'b0;
                  r_state   <= c_st_load;
               end
            end
`ifdef MLP_LOADER_FRAME_CHECK_EN
            c_st_drain: begin
               if (w_accept && s_last)
                  r_state <= c_st_load;
            end
`endif
            default: r_state <= c_st_load;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mlp_feature_loader.sv
// ============================================================================
// Module   : tb_mlp_feature_loader
// Brief    : Directed self-checking bench for mlp_feature_loader with a small
//            behavioural classifier (sum of nibbles mod 4) on cls_in.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mlp_feature_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [3:0]  s_data = 4'h0;
   logic        s_last = 1'b0;
   logic [23:0] feat_vec;
   logic [1:0]  cls_in;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [1:0]  m_class;
   logic        frame_err;

   logic        cls_force = 1'b0;
   logic [1:0]  cls_force_val = 2'b00;

   int total = 0;
   int bad = 0;
   int cyc_cnt = 0;
   int err_seen = 0;
   int valid_seen = 0;

   mlp_feature_loader #(
      .N_FEAT(6), .FEAT_W(4), .CLS_W(2), .SETTLE_CYC(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .feat_vec(feat_vec), .cls_in(cls_in),
      .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] classify(input logic [23:0] v);
      logic [7:0] s;
      s = 8'd0;
      for (int k = 0; k < 6; k++) s = s + {4'd0, v[k*4 +: 4]};
      return s[1:0];
   endfunction

   assign cls_in = cls_force ? cls_force_val : classify(feat_vec);

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if (frame_err) err_seen <= err_seen + 1;
      if (m_valid) valid_seen <= valid_seen + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat, waits (bounded) for s_ready, returns #1 after the accepting edge.
   task automatic beat(input logic [3:0] d, input logic last);
      int n;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      n = 0;
      while (!s_ready && n < 50) begin
         tick();
         n++;
      end
      total++;
      if (!s_ready) begin
         bad++;
         $display("FAIL beat_wait: s_ready=%b after %0d cycles, required 1", s_ready, n);
      end
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!m_valid && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic handshake();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
   endtask

   task automatic send_frame(input logic [23:0] v);
      for (int k = 0; k < 6; k++) beat(v[k*4 +: 4], k == 5);
   endtask

   task automatic test_reset();
      tick();
      tick();
      total++;
      if ({feat_vec, m_valid, m_class, frame_err, s_ready} !== {24'h0, 1'b0, 2'b00, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL reset_vals: feat=%h mv=%b mc=%b err=%b sr=%b, required 000000 0 00 0 1",
                  feat_vec, m_valid, m_class, frame_err, s_ready);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int n;
      send_frame(24'h654321);
      total++;
      if (feat_vec !== 24'h654321) begin
         bad++;
         $display("FAIL basic_feat: got %h, required 654321", feat_vec);
      end
      total++;
      if (s_ready !== 1'b0) begin
         bad++;
         $display("FAIL basic_settle_ready: s_ready=%b, required 0", s_ready);
      end
      wait_valid(n);
      total++;
      if (n != 4) begin
         bad++;
         $display("FAIL basic_latency: m_valid after %0d cycles, required 4", n);
      end
      total++;
      if (m_class !== 2'd1) begin
         bad++;
         $display("FAIL basic_class: got %0d, required 1", m_class);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if ({s_ready, m_valid, m_class} !== {1'b0, 1'b1, 2'd1}) begin
            bad++;
            $display("FAIL hold_stable[%0d]: sr=%b mv=%b mc=%0d, required sr=0 mv=1 mc=1",
                     i, s_ready, m_valid, m_class);
         end
      end
      handshake();
      total++;
      if ({m_valid, s_ready} !== 2'b01) begin
         bad++;
         $display("FAIL hold_release: mv=%b sr=%b, required mv=0 sr=1", m_valid, s_ready);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int t[3];
      logic [23:0] frames [3];
      logic [1:0]  cls [3];
      frames[0] = 24'h100000; cls[0] = 2'd1;
      frames[1] = 24'hfedcba; cls[1] = 2'd3;
      frames[2] = 24'h777777; cls[2] = 2'd2;
      m_ready = 1'b1;
      for (int f = 0; f < 3; f++) begin
         send_frame(frames[f]);
         wait_valid(n);
         t[f] = cyc_cnt;
         total++;
         if (m_valid !== 1'b1 || m_class !== cls[f]) begin
            bad++;
            $display("FAIL b2b_class[%0d]: mv=%b mc=%0d, required mv=1 mc=%0d", f, m_valid, m_class, cls[f]);
         end
      end
      tick();
      m_ready = 1'b0;
      for (int f = 1; f < 3; f++) begin
         total++;
         if (t[f] - t[f-1] != 11) begin
            bad++;
            $display("FAIL b2b_period[%0d]: %0d cycles, required 11", f, t[f] - t[f-1]);
         end
      end
      total++;
      if (m_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_drain: m_valid=%b, required 0", m_valid);
      end
   endtask

   task automatic test_cls_capture();
      int n;
      send_frame(24'h654321);
      cls_force     = 1'b1;
      cls_force_val = 2'b11;
      wait_valid(n);
      total++;
      if (n != 4 || m_class !== 2'b11) begin
         bad++;
         $display("FAIL cap_value: latency=%0d mc=%b, required 4 and 11", n, m_class);
      end
      cls_force_val = 2'b00;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (m_class !== 2'b11) begin
            bad++;
            $display("FAIL cap_hold[%0d]: mc=%b, required 11", i, m_class);
         end
      end
      cls_force = 1'b0;
      handshake();
   endtask

`ifdef MLP_LOADER_FRAME_CHECK_EN
   task automatic test_frame_early();
      int n;
      beat(4'h1, 1'b0);
      beat(4'h2, 1'b0);
      beat(4'h3, 1'b1);
      total++;
      if (frame_err !== 1'b1) begin
         bad++;
         $display("FAIL early_err: frame_err=%b, required 1", frame_err);
      end
      tick();
      total++;
      if ({frame_err, s_ready, m_valid} !== 3'b010) begin
         bad++;
         $display("FAIL early_after: err=%b sr=%b mv=%b, required 0 1 0", frame_err, s_ready, m_valid);
      end
      send_frame(24'h654321);
      wait_valid(n);
      total++;
      if (feat_vec !== 24'h654321 || n != 4 || m_class !== 2'd1) begin
         bad++;
         $display("FAIL early_recover: feat=%h latency=%0d mc=%0d, required 654321 4 1", feat_vec, n, m_class);
      end
      handshake();
   endtask

   task automatic test_drain();
      int n;
      int e0;
      int v0;
      e0 = err_seen;
      v0 = valid_seen;
      for (int k = 0; k < 6; k++) beat(4'h8, 1'b0);
      total++;
      if (frame_err !== 1'b1 || feat_vec[19:0] !== 20'h88888) begin
         bad++;
         $display("FAIL drain_err: err=%b feat_lo=%h, required 1 and 88888", frame_err, feat_vec[19:0]);
      end
      beat(4'hA, 1'b0);
      beat(4'hB, 1'b1);
      total++;
      if (feat_vec[19:0] !== 20'h88888) begin
         bad++;
         $display("FAIL drain_nowrite: feat_lo=%h, required 88888", feat_vec[19:0]);
      end
      repeat (8) tick();
      total++;
      if (err_seen - e0 != 1 || valid_seen - v0 != 0 || s_ready !== 1'b1) begin
         bad++;
         $display("FAIL drain_summary: pulses=%0d valids=%0d sr=%b, required 1 0 1",
                  err_seen - e0, valid_seen - v0, s_ready);
      end
      send_frame(24'h123456);
      wait_valid(n);
      total++;
      if (feat_vec !== 24'h123456 || n != 4 || m_class !== 2'd1) begin
         bad++;
         $display("FAIL drain_recover: feat=%h latency=%0d mc=%0d, required 123456 4 1", feat_vec, n, m_class);
      end
      handshake();
   endtask
`else
   task automatic test_no_check();
      int n;
      int e0;
      e0 = err_seen;
      beat(4'h1, 1'b0);
      beat(4'h2, 1'b0);
      beat(4'h3, 1'b1);
      beat(4'h4, 1'b0);
      beat(4'h5, 1'b0);
      beat(4'h6, 1'b0);
      wait_valid(n);
      total++;
      if (feat_vec !== 24'h654321 || n != 4 || m_class !== 2'd1 || err_seen != e0) begin
         bad++;
         $display("FAIL nocheck_frame: feat=%h latency=%0d mc=%0d pulses=%0d, required 654321 4 1 0",
                  feat_vec, n, m_class, err_seen - e0);
      end
      handshake();
   endtask
`endif

   task automatic test_reset_settle();
      int v0;
      send_frame(24'h654321);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      total++;
      if ({feat_vec, m_valid, m_class, frame_err, s_ready} !== {24'h0, 1'b0, 2'b00, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL rst_settle: feat=%h mv=%b mc=%b err=%b sr=%b, required 000000 0 00 0 1",
                  feat_vec, m_valid, m_class, frame_err, s_ready);
      end
      v0 = valid_seen;
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      total++;
      if (valid_seen != v0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_no_result: valids=%0d mv=%b sr=%b, required 0 0 1", valid_seen - v0, m_valid, s_ready);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_back_to_back();
      test_cls_capture();
`ifdef MLP_LOADER_FRAME_CHECK_EN
      test_frame_early();
      test_drain();
`else
      test_no_check();
`endif
      test_reset_settle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
